// File: rtl/cache_dm_responder.sv
// Direct-mapped, read-only, one-word-line cache with a req/ack refill port.
// Define CACHE_STATS_EN to add saturating hit/miss counters.
module cache_dm_responder #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LINES  = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic              flush_i,
    output logic              resp_valid_o,
    output logic              hit_o,
    output logic [DATA_W-1:0] data_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_data_i
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]       hit_count_o,
    output logic [15:0]       miss_count_o
`endif
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W;

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINES-1:0]    valid_q, valid_d;
    logic [TAG_W-1:0]    tag_q [LINES];
    logic [TAG_W-1:0]    tag_d [LINES];
    logic [DATA_W-1:0]   data_q [LINES];
    logic [DATA_W-1:0]   data_d [LINES];
    logic                resp_valid_q, resp_valid_d;
    logic                hit_q, hit_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;

    logic [IDX_W-1:0]    idx_c;
    logic [TAG_W-1:0]    tag_c;
    logic                lookup_hit_c;

    assign idx_c        = addr_q[IDX_W-1:0];
    assign tag_c        = addr_q[ADDR_W-1:IDX_W];
    assign lookup_hit_c = valid_q[idx_c] && (tag_q[idx_c] == tag_c);

    // Flush wins over a request in the same cycle, so ready drops with it.
    assign req_ready_o  = (state_q == IDLE) && !flush_i;

    assign resp_valid_o = resp_valid_q;
    assign hit_o        = hit_q;
    assign data_o       = rdata_q;
    assign mem_req_o    = mem_req_q;
    assign mem_addr_o   = mem_addr_q;

    // Next-state, line update and response logic
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        data_d       = data_q;
        resp_valid_d = 1'b0;
        hit_d        = hit_q;
        rdata_d      = rdata_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        case (state_q)
            IDLE: begin
                if (flush_i) begin
                    valid_d = '0;
                end else if (req_valid_i && req_ready_o) begin
                    addr_d  = req_addr_i;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (lookup_hit_c) begin
                    resp_valid_d = 1'b1;
                    hit_d        = 1'b1;
                    rdata_d      = data_q[idx_c];
                    state_d      = IDLE;
                end else begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = addr_q;
                    state_d    = REFILL;
                end
            end
            REFILL: begin
                // No dirty state, so a conflicting line is simply overwritten.
                if (mem_ack_i && mem_req_q) begin
                    valid_d[idx_c] = 1'b1;
                    tag_d[idx_c]   = tag_c;
                    data_d[idx_c]  = mem_data_i;
                    mem_req_d      = 1'b0;
                    resp_valid_d   = 1'b1;
                    hit_d          = 1'b0;
                    rdata_d        = mem_data_i;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            valid_q      <= '0;
            resp_valid_q <= 1'b0;
            hit_q        <= 1'b0;
            rdata_q      <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            valid_q      <= valid_d;
            resp_valid_q <= resp_valid_d;
            hit_q        <= hit_d;
            rdata_q      <= rdata_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    // Tag and data storage are qualified by valid bits and need no reset.
    always_ff @(posedge clk_i) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    // Counters step with the response pulse and saturate at all-ones.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if ((state_q == IDLE) && flush_i) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
        end else if (resp_valid_d) begin
            if (hit_d && (hit_cnt_q != 16'hFFFF)) begin
                hit_cnt_d = hit_cnt_q + 16'd1;
            end else if (!hit_d && (miss_cnt_q != 16'hFFFF)) begin
                miss_cnt_d = miss_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_dm_responder.sv
// Self-checking bench for cache_dm_responder against an address-keyed cache model.
module tb_cache_dm_responder;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LINES  = 64;
    localparam int          BUDGET = 60;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              req_valid_i = 1'b0;
    logic              req_ready_o;
    logic [ADDR_W-1:0] req_addr_i = '0;
    logic              flush_i = 1'b0;
    logic              resp_valid_o;
    logic              hit_o;
    logic [DATA_W-1:0] data_o;
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_ack_i = 1'b0;
    logic [DATA_W-1:0] mem_data_i = '0;
`ifdef CACHE_STATS_EN
    logic [15:0]       hit_count_o;
    logic [15:0]       miss_count_o;
`endif

    cache_dm_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINES(LINES)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .flush_i(flush_i),
        .resp_valid_o(resp_valid_o), .hit_o(hit_o), .data_o(data_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i)
`ifdef CACHE_STATS_EN
        , .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    // Model: each line remembers the full address it holds.
    bit                model_valid [LINES];
    logic [ADDR_W-1:0] model_addr  [LINES];
    logic [DATA_W-1:0] model_data  [LINES];
    int                model_hits = 0;
    int                model_misses = 0;
    logic              e_hit;
    logic [DATA_W-1:0] e_data;

    // Observations from the last access
    bit                r_saw, r_stable, r_rdy, r_pulse, r_to;
    logic [ADDR_W-1:0] r_addr;
    logic              r_hit;
    logic [DATA_W-1:0] r_data;
    int                r_lat;

    function automatic void model_clear();
        for (int i = 0; i < int'(LINES); i++) model_valid[i] = 1'b0;
        model_hits   = 0;
        model_misses = 0;
    endfunction

    function automatic void model_step(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] fill);
        int ln;
        ln     = int'(a) % int'(LINES);
        e_hit  = model_valid[ln] && (model_addr[ln] == a);
        e_data = e_hit ? model_data[ln] : fill;
        if (e_hit) begin
            if (model_hits < 65535) model_hits++;
        end else begin
            model_valid[ln] = 1'b1;
            model_addr[ln]  = a;
            model_data[ln]  = fill;
            if (model_misses < 65535) model_misses++;
        end
    endfunction

    // Drive one request, serve any refill after ack_dly cycles, record what came back.
    task automatic run_access(input logic [ADDR_W-1:0] addr, input int ack_dly,
                              input logic [DATA_W-1:0] fill, input bit flush_in_lookup);
        int wait_cnt;
        int ack_cyc;
        bit done;
        r_saw = 0; r_addr = '0; r_stable = 1; r_hit = 1'b0; r_data = '0; r_lat = 0;
        r_rdy = 0; r_pulse = 0; r_to = 0;
        wait_cnt = 0; ack_cyc = -1; done = 0;
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_addr_i  = addr;
        for (int i = 1; i <= BUDGET && !done; i++) begin
            @(negedge clk_i);
            req_valid_i = 1'b0;
            mem_ack_i   = 1'b0;
            if (i == 1) begin
                r_rdy   = req_ready_o;
                flush_i = flush_in_lookup;
            end else begin
                flush_i = 1'b0;
            end
            if (resp_valid_o) begin
                r_hit  = hit_o;
                r_data = data_o;
                r_lat  = (ack_cyc < 0) ? i : i - ack_cyc;
                done   = 1;
            end else if (mem_req_o) begin
                if (!r_saw) begin
                    r_saw  = 1;
                    r_addr = mem_addr_o;
                end else if (mem_addr_o !== r_addr) begin
                    r_stable = 0;
                end
                if (wait_cnt == ack_dly) begin
                    mem_ack_i  = 1'b1;
                    mem_data_i = fill;
                    ack_cyc    = i;
                end
                wait_cnt++;
            end
        end
        mem_ack_i = 1'b0;
        flush_i   = 1'b0;
        if (!done) begin
            r_to = 1;
        end else begin
            @(negedge clk_i);
            r_pulse = !resp_valid_o;
        end
    endtask

    task automatic flush_idle();
        @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        model_clear();
        #1;
        checks++;
        if ({resp_valid_o, hit_o, data_o, mem_req_o, mem_addr_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: resp_valid=%b hit=%b data=%h mem_req=%b mem_addr=%h, all must be 0",
                     resp_valid_o, hit_o, data_o, mem_req_o, mem_addr_o);
        end
`ifdef CACHE_STATS_EN
        checks++;
        if (hit_count_o !== 16'd0 || miss_count_o !== 16'd0) begin
            failures++;
            $display("FAIL reset_counters: hit=%0d miss=%0d, need 0/0", hit_count_o, miss_count_o);
        end
`endif
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        checks++;
        if (req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: req_ready=%b, need 1", req_ready_o);
        end
    endtask

    task automatic test_cold_miss();
        model_step(16'h0010, 32'hDEADBEEF);
        run_access(16'h0010, 3, 32'hDEADBEEF, 1'b0);
        checks++;
        if (r_to || !r_saw || r_addr !== 16'h0010 || !r_stable) begin
            failures++;
            $display("FAIL cold_miss_req: timeout=%0d saw=%0d addr=%h stable=%0d, need req at 0010 held",
                     r_to, r_saw, r_addr, r_stable);
        end
        checks++;
        if (r_hit !== 1'b0 || r_data !== 32'hDEADBEEF || r_lat != 1 || !r_pulse) begin
            failures++;
            $display("FAIL cold_miss_resp: hit=%b data=%h lat=%0d pulse=%0d, need 0 deadbeef 1 1",
                     r_hit, r_data, r_lat, r_pulse);
        end
    endtask

    task automatic test_hit();
        model_step(16'h0010, 32'h0);
        run_access(16'h0010, 0, 32'h0, 1'b0);
        checks++;
        if (r_to || r_saw || r_hit !== 1'b1 || r_data !== 32'hDEADBEEF || r_lat != 2 || !r_pulse) begin
            failures++;
            $display("FAIL hit: timeout=%0d memreq=%0d hit=%b data=%h lat=%0d pulse=%0d, need 0 0 1 deadbeef 2 1",
                     r_to, r_saw, r_hit, r_data, r_lat, r_pulse);
        end
    endtask

    task automatic test_conflict();
        model_step(16'h0050, 32'h12345678);
        run_access(16'h0050, 1, 32'h12345678, 1'b0);
        checks++;
        if (r_to || !r_saw || r_addr !== 16'h0050 || r_hit !== 1'b0 || r_data !== 32'h12345678) begin
            failures++;
            $display("FAIL conflict_0050: saw=%0d addr=%h hit=%b data=%h, need miss 0050 12345678",
                     r_saw, r_addr, r_hit, r_data);
        end
        model_step(16'h0010, 32'hDEADBEEF);
        run_access(16'h0010, 2, 32'hDEADBEEF, 1'b0);
        checks++;
        if (r_to || !r_saw || r_addr !== 16'h0010 || r_hit !== 1'b0 || r_data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL conflict_0010: saw=%0d addr=%h hit=%b data=%h, need miss 0010 deadbeef",
                     r_saw, r_addr, r_hit, r_data);
        end
    endtask

    task automatic test_flush();
        bit busy;
        model_step(16'h0050, 32'h12345678);
        run_access(16'h0050, 0, 32'h12345678, 1'b0);
        @(negedge clk_i);
        flush_i     = 1'b1;
        req_valid_i = 1'b1;
        req_addr_i  = 16'h0050;
        #1;
        checks++;
        if (req_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_ready: req_ready=%b during flush, need 0", req_ready_o);
        end
        @(negedge clk_i);
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        model_clear();
        busy = 0;
        for (int i = 0; i < 3; i++) begin
            if (resp_valid_o || mem_req_o) busy = 1;
            @(negedge clk_i);
        end
        checks++;
        if (busy) begin
            failures++;
            $display("FAIL flush_no_accept: activity=%0d after flush-cycle request, need 0", busy);
        end
        model_step(16'h0050, 32'h0BADF00D);
        run_access(16'h0050, 2, 32'h0BADF00D, 1'b0);
        checks++;
        if (r_to || !r_saw || r_hit !== 1'b0 || r_data !== 32'h0BADF00D) begin
            failures++;
            $display("FAIL flush_miss: saw=%0d hit=%b data=%h, need miss 0badf00d", r_saw, r_hit, r_data);
        end
    endtask

    task automatic test_flush_outside_idle();
        model_step(16'h0050, 32'h0);
        run_access(16'h0050, 0, 32'h0, 1'b1);
        model_step(16'h0050, 32'h0);
        run_access(16'h0050, 0, 32'h0, 1'b0);
        checks++;
        if (r_to || r_saw || r_hit !== 1'b1 || r_data !== e_data) begin
            failures++;
            $display("FAIL flush_ignored: saw=%0d hit=%b data=%h, need hit %h", r_saw, r_hit, r_data, e_data);
        end
    endtask

    task automatic test_reset_mid_refill();
        bit busy;
        flush_idle();
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_addr_i  = 16'h0777;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (mem_req_o !== 1'b1) begin
            failures++;
            $display("FAIL midrefill_req: mem_req=%b, need 1", mem_req_o);
        end
        #2 rst_i = 1'b1;
        #1;
        model_clear();
        checks++;
        if (mem_req_o !== 1'b0 || resp_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL midrefill_async: mem_req=%b resp_valid=%b, need 0 0", mem_req_o, resp_valid_o);
        end
        @(negedge clk_i);
        rst_i      = 1'b0;
        mem_ack_i  = 1'b1;
        mem_data_i = 32'hCAFEF00D;
        busy = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            mem_ack_i = 1'b0;
            if (resp_valid_o || mem_req_o) busy = 1;
        end
        checks++;
        if (busy) begin
            failures++;
            $display("FAIL late_ack: activity=%0d after late ack, need 0", busy);
        end
        model_step(16'h0777, 32'h01020304);
        run_access(16'h0777, 1, 32'h01020304, 1'b0);
        checks++;
        if (r_to || !r_saw || r_hit !== 1'b0 || r_data !== 32'h01020304) begin
            failures++;
            $display("FAIL after_reset_miss: saw=%0d hit=%b data=%h, need miss 01020304", r_saw, r_hit, r_data);
        end
    endtask

    task automatic test_boundary();
        logic [ADDR_W-1:0] addrs [2];
        logic [DATA_W-1:0] d;
        addrs[0] = 16'h0000;
        addrs[1] = 16'hFFFF;
        for (int k = 0; k < 2; k++) begin
            for (int rep = 0; rep < 2; rep++) begin
                d = $urandom;
                model_step(addrs[k], d);
                run_access(addrs[k], 1, d, 1'b0);
                checks++;
                if (r_to || r_hit !== e_hit || r_data !== e_data || r_saw == e_hit
                    || (!e_hit && r_addr !== addrs[k])) begin
                    failures++;
                    $display("FAIL boundary_%h: hit=%b data=%h memaddr=%h, need hit=%b data=%h",
                             addrs[k], r_hit, r_data, r_addr, e_hit, e_data);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        model_step(16'h1234, 32'hA5A5_5A5A);
        run_access(16'h1234, 0, 32'hA5A5_5A5A, 1'b0);
        checks++;
        if (r_rdy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ready: req_ready=%b in lookup, need 0", r_rdy);
        end
        model_step(16'h1234, 32'h0);
        run_access(16'h1234, 0, 32'h0, 1'b0);
        checks++;
        if (r_to || r_saw || r_hit !== 1'b1 || r_data !== 32'hA5A5_5A5A || r_lat != 2) begin
            failures++;
            $display("FAIL b2b_hit: hit=%b data=%h lat=%0d, need 1 a5a55a5a 2", r_hit, r_data, r_lat);
        end
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        int errs;
        errs = 0;
        flush_idle();
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 11) == 0) flush_idle();
            a = ADDR_W'(($urandom_range(0, 3) << 6) | $urandom_range(0, 7));
            d = $urandom;
            model_step(a, d);
            run_access(a, int'($urandom_range(0, 4)), d, 1'b0);
            checks++;
            if (r_to || r_hit !== e_hit || r_data !== e_data || r_saw == e_hit
                || (!e_hit && r_addr !== a) || r_lat != (e_hit ? 2 : 1) || !r_pulse) begin
                failures++;
                errs++;
                if (errs < 5)
                    $display("FAIL random_%0d addr=%h: hit=%b data=%h lat=%0d memreq=%0d, need hit=%b data=%h",
                             n, a, r_hit, r_data, r_lat, r_saw, e_hit, e_data);
            end
        end
`ifdef CACHE_STATS_EN
        checks++;
        if (int'(hit_count_o) != model_hits || int'(miss_count_o) != model_misses) begin
            failures++;
            $display("FAIL random_counters: hit=%0d miss=%0d, need %0d/%0d",
                     hit_count_o, miss_count_o, model_hits, model_misses);
        end
`endif
    endtask

`ifdef CACHE_STATS_EN
    task automatic test_stats();
        logic [ADDR_W-1:0] seq [5];
        seq[0] = 16'h0200; seq[1] = 16'h0200; seq[2] = 16'h0301; seq[3] = 16'h0301; seq[4] = 16'h0200;
        flush_idle();
        for (int k = 0; k < 5; k++) begin
            model_step(seq[k], 32'h1000 + k);
            run_access(seq[k], 1, 32'h1000 + k, 1'b0);
        end
        checks++;
        if (hit_count_o !== 16'd3 || miss_count_o !== 16'd2) begin
            failures++;
            $display("FAIL stats_count: hit=%0d miss=%0d, need 3/2", hit_count_o, miss_count_o);
        end
        flush_idle();
        checks++;
        if (hit_count_o !== 16'd0 || miss_count_o !== 16'd0) begin
            failures++;
            $display("FAIL stats_flush: hit=%0d miss=%0d, need 0/0", hit_count_o, miss_count_o);
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_flush();
        test_flush_outside_idle();
        test_reset_mid_refill();
        test_boundary();
        test_back_to_back();
        test_random();
`ifdef CACHE_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_dm_responder.md
Name: cache_dm_responder

Overview:
- Direct-mapped, read-only cache that serves the core's physical-address stream and returns a hit flag plus a 32-bit data word per access.
- It is the responder end of the core access interface driven by the access-log testbench.
- Misses are refilled from a backing memory over a simple request/acknowledge port.
- It sits between the core address generator and the backing memory model.

Parameters:
- ADDR_W, 16, physical word-address width.
- DATA_W, 32, data word width.
- LINES, 64, number of one-word cache lines; power of two, minimum 2.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  core access request.
- req_ready_o  out  1  cache can accept a request this cycle.
- req_addr_i  in  ADDR_W  physical word address.
- flush_i  in  1  invalidate all lines.
- resp_valid_o  out  1  one-cycle response pulse.
- hit_o  out  1  response was a hit; qualified by resp_valid_o.
- data_o  out  DATA_W  response data; qualified by resp_valid_o.
- mem_req_o  out  1  refill request to backing memory.
- mem_addr_o  out  ADDR_W  refill address.
- mem_ack_i  in  1  refill data valid.
- mem_data_i  in  DATA_W  refill data.

Behaviour:
- Reset and interface
  - Clock is clk_i. Reset rst_i is asynchronous, active-high.
  - On reset: all outputs are 0, every valid bit is cleared, FSM goes to IDLE.
  - Address split: index = req_addr_i[log2(LINES)-1:0]; tag = the remaining upper bits.
  - Storage per line: valid bit, tag, data word, all in registers.
  - req_ready_o = (state==IDLE) && !flush_i, combinational.
  - A request is accepted when req_valid_i && req_ready_o; the address is captured into addr_q.
- FSM
  - IDLE: if flush_i, clear all valid bits in one cycle and stay in IDLE (flush has priority over requests). Else on accept, go to LOOKUP.
  - LOOKUP: if valid[idx] && tag[idx]==tag(addr_q), this is a hit.
    - Hit: register resp_valid_o=1, hit_o=1, data_o=data[idx]; go to IDLE.
    - Miss: register mem_req_o=1, mem_addr_o=addr_q; go to REFILL.
  - REFILL: mem_req_o and mem_addr_o are held stable until mem_ack_i. mem_ack_i is ignored whenever mem_req_o=0.
  - On ack:
    - Write the line: valid=1, tag, data=mem_data_i.
    - Drop mem_req_o.
    - Register resp_valid_o=1, hit_o=0, data_o=mem_data_i.
    - Go to IDLE.
- Latency
  - Hit: resp_valid_o is high 2 cycles after the accept edge.
  - Miss: resp_valid_o is high 1 cycle after the mem_ack_i edge.
- Response outputs
  - resp_valid_o is a single-cycle pulse with no backpressure.
  - hit_o and data_o hold their last values after the pulse.
- Boundary conditions
  - flush_i outside IDLE is ignored and not remembered.
  - A refill overwrites a conflicting line unconditionally, because the cache is read-only and holds no dirty state.
  - Two back-to-back accesses to the same address: the second one hits.
  - Minimum request spacing is 2 cycles, because req_ready_o is low outside IDLE.
  - Reset asserted mid-REFILL drops mem_req_o immediately and asynchronously, and no response is issued. A late mem_ack_i is then ignored because mem_req_o=0.
  - Address 0 and address 2^ADDR_W-1 map normally; there is no wrap special case.

Optional Feature:
- Macro: CACHE_STATS_EN.
- When defined, two extra outputs are present:
  - hit_count_o, 16 bits.
  - miss_count_o, 16 bits.
- Counter rules:
  - Each counter increments on the resp_valid_o rising cycle, selected by hit_o.
  - Each counter saturates at 0xFFFF.
  - Both clear on rst_i and on an accepted flush_i.
- When the macro is undefined, these ports and counters do not exist, and all other behaviour is identical.

Test Plan:
1. Cold miss: after reset, request 0x0010; memory acks 3 cycles after mem_req_o with 0xDEADBEEF.
   -> mem_addr_o=0x0010; resp_valid_o pulse with hit_o=0, data_o=0xDEADBEEF one cycle after the ack.
2. Re-access 0x0010.
   -> no mem_req_o; resp_valid_o 2 cycles after accept with hit_o=1, data_o=0xDEADBEEF.
3. Conflict: 0x0050 (same index 16, tag 1) refilled with 0x12345678, then request 0x0010.
   -> 0x0050 misses; 0x0010 misses again with mem_addr_o=0x0010.
4. Flush: pulse flush_i in IDLE with req_valid_i=1 that cycle, then request 0x0050.
   -> req_ready_o=0 during the flush cycle; 0x0050 then misses.
5. Reset mid-refill: assert rst_i while mem_req_o=1, release it, then drive mem_ack_i.
   -> mem_req_o=0 immediately; no resp_valid_o; next request to the same address misses.
6. With CACHE_STATS_EN defined, run the sequence: miss, hit, miss, hit, hit.
   -> hit_count_o=3, miss_count_o=2; both read 0 after flush.
